mux4_rr_arbiter: RTL and testbench

//  Shares one 4:1 bit-select path (mux4to1) between four requesters. Registered

---
 rtl/mux4_rr_arbiter_pkg.sv | 34 +++
 rtl/mux4_rr_arbiter_mux4to1.sv | 22 ++
 rtl/mux4_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter that owns a 4:1 bit-select path.
// Provides the FSM encoding, requester count, default hold limit and the rotating priority search.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int NUM_REQ          = 4;
    localparam int DEFAULT_MAX_HOLD = 8;

    typedef logic [1:0] idx_t;

    // Checks requesters in the order ptr, ptr+1, ptr+2, ptr+3 (index wraps mod 4).
    // The first requester found with req set wins.
    // If req is all zero the result is ptr, so callers check |req before using it.
    function automatic idx_t rr_pick(input logic [NUM_REQ-1:0] req, input idx_t ptr);
        idx_t w;
        idx_t c;
        logic found;
        w     = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = ptr + idx_t'(k);
            if (!found && req[c]) begin
                w     = c;
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4to1.sv
// Plain 4:1 single-bit multiplexer.
// {a,b} selects which data input drives y.
module mux4to1 (
    output logic y,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic a,
    input  logic b
);

    always_comb begin
        case ({a, b})
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Registered round-robin arbiter that shares one 4:1 mux among four requesters.
// An owner keeps the grant for at most MAX_HOLD cycles while others wait; y is forced to 0 when idle.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       d0,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    output logic [3:0] gnt,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       y
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    idx_t               sel_q, sel_d;
    idx_t               ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [3:0]         others;
    idx_t               idle_pick;
    idx_t               next_pick;
    logic               y_raw;

    // The requesters other than the current owner compete for the next grant.
    assign others    = req & ~(4'b0001 << sel_q);
    assign idle_pick = rr_pick(req, ptr_q);
    assign next_pick = rr_pick(others, sel_q + 2'd1);

    // NOTE: each next-state signal is given its current value first.
    // This means every path through the case assigns it, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = idle_pick;
                    gnt_d   = 4'b0001 << idle_pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!req[sel_q] || (cnt_q == CNT_MAX && |others)) begin
                    // The owner either releases or is preempted.
                    // Hand over directly to the next waiter; go idle only if nobody is waiting.
                    ptr_d = sel_q + 2'd1;
                    cnt_d = '0;
                    if (|others) begin
                        sel_d = next_pick;
                        gnt_d = 4'b0001 << next_pick;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments.
    // All flops then update together from the values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    mux4to1 u_mux (
        .y  (y_raw),
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .a  (sel_q[1]),
        .b  (sel_q[0])
    );

    assign gnt  = gnt_q;
    assign a    = sel_q[1];
    assign b    = sel_q[0];
    assign busy = (state_q == GRANT);
    // While idle the select still holds the last owner, so y is masked with busy.
    assign y    = y_raw & busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter.
// Runs a table of vectors plus hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       a, b, busy, y;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] d;
        logic [3:0] gnt;
        logic [1:0] ab;
        logic       busy;
        logic       y;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[16];

    mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .d0   (d[0]),
        .d1   (d[1]),
        .d2   (d[2]),
        .d3   (d[3]),
        .gnt  (gnt),
        .a    (a),
        .b    (b),
        .busy (busy),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mk(input logic [3:0] g, input logic [1:0] ab,
                                      input logic bz, input logic yy);
        return {g, ab, bz, yy};
    endfunction

    task automatic compare_front();
        sb_t        e;
        logic [7:0] act;
        if (sb_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL scoreboard: got empty queue, want one pending entry");
            return;
        end
        e   = sb_q.pop_front();
        act = {gnt, a, b, busy, y};
        n_compared++;
        if (act !== e.exp) begin
            n_mismatched++;
            $display("FAIL %s: got gnt=%b ab=%b busy=%b y=%b, want gnt=%b ab=%b busy=%b y=%b",
                     e.name, act[7:4], act[3:2], act[1], act[0],
                     e.exp[7:4], e.exp[3:2], e.exp[1], e.exp[0]);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    // The outputs are checked just after that edge, while the inputs are still held.
    task automatic step(input string name, input logic r, input logic [3:0] rq,
                        input logic [3:0] dv, input logic [7:0] exp);
        @(negedge clk);
        rst = r;
        req = rq;
        d   = dv;
        sb_q.push_back('{name, exp});
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        logic [3:0] dpat;
        int         owner;

        rst = 1'b1;
        req = 4'b0000;
        d   = 4'b0000;

        //             rst   req      d        gnt      ab     busy  y
        vecs[0]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b0101, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'b10, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 2'b00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 4'b1001, 4'b1000, 4'b1000, 2'b11, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 4'b1001, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 4'b0010, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 4'b0011, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].d,
                 mk(vecs[i].gnt, vecs[i].ab, vecs[i].busy, vecs[i].y));
        end

        // A lone owner is never preempted and keeps the grant for 20 cycles.
        // Here ptr=1 and the search wraps round to requester 0.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("lone_hold%0d", i), 1'b0, 4'b0001, {3'b000, i[0]},
                 mk(4'b0001, 2'b00, 1'b1, i[0]));
        end
        // The hold count is saturated, so a newly arriving waiter takes over at the next edge.
        step("late_waiter_preempt", 1'b0, 4'b0011, 4'b0010, mk(4'b0010, 2'b01, 1'b1, 1'b1));
        step("release_to_idle",     1'b0, 4'b0000, 4'b0010, mk(4'b0000, 2'b01, 1'b0, 1'b0));

        // All four requesters are held: each gets 8 cycles in turn, with no idle cycle between.
        step("rr_reset", 1'b1, 4'b0000, 4'b1111, mk(4'b0000, 2'b00, 1'b0, 1'b0));
        dpat = 4'b1010;
        for (int n = 0; n < 40; n++) begin
            owner = (n / 8) % 4;
            step($sformatf("rr_cycle%0d", n), 1'b0, 4'b1111, dpat,
                 mk(4'b0001 << owner, owner[1:0], 1'b1, dpat[owner]));
        end
        step("rr_drop_all", 1'b0, 4'b0000, dpat, mk(4'b0000, 2'b00, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
